// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// master = datapath side (drives IR opcode / flags), slave = controller.
interface mc_controller_if;
  logic       run;
  logic [3:0] opcode;
  logic       compare;
  logic [2:0] Mux1_alu_B;
  logic [2:0] Mux2_alu_A;
  logic [1:0] Mux3_RF_wen;
  logic [2:0] Mux4_RF_wadd;
  logic [1:0] Mux5_RF_read2;
  logic       Mux6_RF_dataIn;
  logic [1:0] Mux8_memwrite;
  logic       Mux9_memDataIn;
  logic       CZen;
  logic       ALU_op;
  logic       memRead;
  logic       wIR;
  logic       wtmpA;
  logic [2:0] counter;
  logic       busy;
  logic       halted;

  modport master (
    output run, opcode, compare,
    input  Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
           Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZen, ALU_op,
           memRead, wIR, wtmpA, counter, busy, halted
  );

  modport slave (
    input  run, opcode, compare,
    output Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
           Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZen, ALU_op,
           memRead, wIR, wtmpA, counter, busy, halted
  );
endinterface

// File: rtl/mc_controller.sv
// Moore multicycle control FSM for the 16-bit RISC datapath: fetch, decode,
// execute, memory, write-back, and the 8-slot LM/SM register walk.
module mc_controller #(
  parameter logic [3:0] HALT_OP    = 4'b1111,
  parameter logic [2:0] MULTI_LAST = 3'd7
) (
  input logic            clk,
  input logic            reset,
  mc_controller_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_ADI = 4'b0001, OP_NDU = 4'b0010,
                         OP_LHI = 4'b0011, OP_LW  = 4'b0100, OP_SW  = 4'b0101,
                         OP_LM  = 4'b0110, OP_SM  = 4'b0111, OP_JAL = 4'b1000,
                         OP_JLR = 4'b1001, OP_BEQ = 4'b1100;

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_D, S_EX, S_WB, S_EA, S_MEM,
    S_BT, S_PCW, S_LNK, S_MA, S_MX, S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] counter_q, counter_d;
  state_e     end_st;
  logic [3:0] op;

  logic [2:0] m1, m2, m4;
  logic [1:0] m3, m5, m8;
  logic       m6, m9, cz, aop, mr, wir, wtmpa, busy, halted;

  assign op     = bus.opcode;
  // run is consulted only at instruction boundaries
  assign end_st = bus.run ? S_F1 : S_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_D;
      S_D: begin
        if (op == HALT_OP) state_d = S_HALT;
        else begin
          case (op)
            OP_ADD, OP_NDU, OP_ADI, OP_LHI,
            OP_BEQ, OP_JAL, OP_JLR:         state_d = S_EX;
            OP_LW, OP_SW:                   state_d = S_EA;
            OP_LM, OP_SM:                   state_d = S_MA;
            default:                        state_d = end_st;
          endcase
        end
      end
      S_EX: begin
        case (op)
          OP_BEQ:         state_d = bus.compare ? S_BT : end_st;
          OP_JAL, OP_JLR: state_d = S_LNK;
          default:        state_d = S_WB;
        endcase
      end
      S_WB, S_MEM, S_PCW: state_d = end_st;
      S_EA:               state_d = S_MEM;
      S_BT, S_LNK:        state_d = S_PCW;
      S_MA:               state_d = S_MX;
      S_MX: begin
        if (counter_q == MULTI_LAST) begin
          counter_d = '0;
          state_d   = end_st;
        end else begin
          counter_d = counter_q + 3'd1;
          state_d   = S_MA;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset also forces the default vector combinationally so no write escapes.
  always_comb begin
    m1 = '0; m2 = '0; m3 = '0; m4 = '0; m5 = '0; m6 = 1'b0; m8 = '0; m9 = 1'b0;
    cz = 1'b0; aop = 1'b0; mr = 1'b0; wir = 1'b0; wtmpa = 1'b0;
    busy = 1'b0; halted = 1'b0;
    if (!reset) begin
      busy   = (state_q != S_IDLE) && (state_q != S_HALT);
      halted = (state_q == S_HALT);
      case (state_q)
        S_F1: begin m5 = 2'd2; m1 = 3'd2; end
        S_F2: begin mr = 1'b1; wir = 1'b1; m5 = 2'd2; m1 = 3'd2; m2 = 3'd1; end
        S_D:  begin m3 = 2'd1; m4 = 3'd3; m6 = 1'b1; wtmpa = 1'b1; end
        S_EX: begin
          case (op)
            OP_ADD, OP_NDU: begin m2 = 3'd5; m1 = 3'd2; aop = op[1]; cz = 1'b1; end
            OP_ADI:         begin m2 = 3'd5; m1 = 3'd3; cz = 1'b1; end
            OP_LHI:         m2 = 3'd2;
            OP_BEQ:         begin m2 = 3'd5; m1 = 3'd2; end
            OP_JAL, OP_JLR: begin m5 = 2'd2; m1 = 3'd2; end
            default: ;
          endcase
        end
        S_WB: begin
          m6 = 1'b1;
          case (op)
            OP_ADD, OP_NDU: begin m4 = 3'd1; m3 = 2'd2; end
            OP_ADI:         begin m4 = 3'd4; m3 = 2'd1; end
            default:        begin m4 = 3'd0; m3 = 2'd1; end
          endcase
        end
        S_EA: begin m1 = 3'd2; m2 = 3'd3; end
        S_MEM: begin
          if (op == OP_LW) begin mr = 1'b1; m3 = 2'd1; end
          else if (op == OP_SW) m8 = 2'd1;
        end
        S_BT:  begin m5 = 2'd2; m1 = 3'd2; m2 = 3'd3; end
        S_PCW: begin m3 = 2'd1; m4 = 3'd3; m6 = 1'b1; end
        S_LNK: begin
          m6 = 1'b1; m3 = 2'd1; m1 = 3'd2;
          if (op != OP_JLR) begin m5 = 2'd2; m2 = 3'd4; end
        end
        S_MA: begin m2 = 3'd6; m1 = 3'd4; end
        S_MX: begin
          if (op == OP_SM) begin m5 = 2'd1; m9 = 1'b1; m8 = 2'd2; end
          else begin mr = 1'b1; m4 = 3'd2; m3 = 2'd3; end
        end
        default: ;
      endcase
    end
  end

  assign bus.Mux1_alu_B     = m1;
  assign bus.Mux2_alu_A     = m2;
  assign bus.Mux3_RF_wen    = m3;
  assign bus.Mux4_RF_wadd   = m4;
  assign bus.Mux5_RF_read2  = m5;
  assign bus.Mux6_RF_dataIn = m6;
  assign bus.Mux8_memwrite  = m8;
  assign bus.Mux9_memDataIn = m9;
  assign bus.CZen           = cz;
  assign bus.ALU_op         = aop;
  assign bus.memRead        = mr;
  assign bus.wIR            = wir;
  assign bus.wtmpA          = wtmpa;
  assign bus.counter        = counter_q;
  assign bus.busy           = busy;
  assign bus.halted         = halted;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction micro-step reference, instruction
// length table, and hand sequences for reset, run=0 and HALT.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus ();
  mc_controller dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct packed {
    logic [2:0] m1, m2;
    logic [1:0] m3;
    logic [2:0] m4;
    logic [1:0] m5;
    logic       m6;
    logic [1:0] m8;
    logic       m9, cz, aop, mr, wir, wtmpa;
    logic [2:0] cnt;
    logic       busy, halted;
  } ctl_t;

  typedef struct {
    logic [3:0] op;
    logic       cmp;
    int         len;
    string      name;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  ctl_t exp_q[$];
  vec_t tbl[14];

  function automatic ctl_t sample();
    ctl_t c;
    c.m1 = bus.Mux1_alu_B;      c.m2 = bus.Mux2_alu_A;     c.m3 = bus.Mux3_RF_wen;
    c.m4 = bus.Mux4_RF_wadd;    c.m5 = bus.Mux5_RF_read2;  c.m6 = bus.Mux6_RF_dataIn;
    c.m8 = bus.Mux8_memwrite;   c.m9 = bus.Mux9_memDataIn; c.cz = bus.CZen;
    c.aop = bus.ALU_op;         c.mr = bus.memRead;        c.wir = bus.wIR;
    c.wtmpa = bus.wtmpA;        c.cnt = bus.counter;       c.busy = bus.busy;
    c.halted = bus.halted;
    return c;
  endfunction

  task automatic chk_ctl(input string name, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic ctl_t blank();
    ctl_t c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  function automatic ctl_t read_pc();
    ctl_t c = blank();
    c.m5 = 2'd2; c.m1 = 3'd2;
    return c;
  endfunction

  function automatic ctl_t pc_write();
    ctl_t c = blank();
    c.m3 = 2'd1; c.m4 = 3'd3; c.m6 = 1'b1;
    return c;
  endfunction

  // Reference: the ordered list of control words an instruction produces.
  task automatic build(input logic [3:0] op, input logic cmp);
    ctl_t c;
    exp_q.delete();
    exp_q.push_back(read_pc());
    c = read_pc(); c.mr = 1'b1; c.wir = 1'b1; c.m2 = 3'd1; exp_q.push_back(c);
    c = pc_write(); c.wtmpa = 1'b1; exp_q.push_back(c);
    case (op)
      4'b0000, 4'b0010: begin
        c = blank(); c.m2 = 3'd5; c.m1 = 3'd2; c.aop = op[1]; c.cz = 1'b1; exp_q.push_back(c);
        c = blank(); c.m6 = 1'b1; c.m4 = 3'd1; c.m3 = 2'd2; exp_q.push_back(c);
      end
      4'b0001: begin
        c = blank(); c.m2 = 3'd5; c.m1 = 3'd3; c.cz = 1'b1; exp_q.push_back(c);
        c = blank(); c.m6 = 1'b1; c.m4 = 3'd4; c.m3 = 2'd1; exp_q.push_back(c);
      end
      4'b0011: begin
        c = blank(); c.m2 = 3'd2; exp_q.push_back(c);
        c = blank(); c.m6 = 1'b1; c.m3 = 2'd1; exp_q.push_back(c);
      end
      4'b0100, 4'b0101: begin
        c = blank(); c.m1 = 3'd2; c.m2 = 3'd3; exp_q.push_back(c);
        c = blank();
        if (op[0]) c.m8 = 2'd1;
        else begin c.mr = 1'b1; c.m3 = 2'd1; end
        exp_q.push_back(c);
      end
      4'b1100: begin
        c = blank(); c.m2 = 3'd5; c.m1 = 3'd2; exp_q.push_back(c);
        if (cmp) begin
          c = read_pc(); c.m2 = 3'd3; exp_q.push_back(c);
          exp_q.push_back(pc_write());
        end
      end
      4'b1000, 4'b1001: begin
        exp_q.push_back(read_pc());
        c = blank(); c.m6 = 1'b1; c.m3 = 2'd1; c.m1 = 3'd2;
        if (!op[0]) begin c.m5 = 2'd2; c.m2 = 3'd4; end
        exp_q.push_back(c);
        exp_q.push_back(pc_write());
      end
      4'b0110, 4'b0111: begin
        for (int i = 0; i < 8; i++) begin
          c = blank(); c.m2 = 3'd6; c.m1 = 3'd4; c.cnt = 3'(i); exp_q.push_back(c);
          c = blank(); c.cnt = 3'(i);
          if (op[0]) begin c.m5 = 2'd1; c.m9 = 1'b1; c.m8 = 2'd2; end
          else begin c.mr = 1'b1; c.m4 = 3'd2; c.m3 = 2'd3; end
          exp_q.push_back(c);
        end
      end
      default: ;
    endcase
  endtask

  // Entered at the last sample point of the previous instruction (run=1).
  task automatic run_model(input logic [3:0] op, input logic cmp);
    build(op, cmp);
    @(posedge clk); #1;
    bus.opcode  = op;
    bus.compare = cmp;
    foreach (exp_q[k]) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      chk_ctl($sformatf("op%b_c%0d_step%0d", op, cmp, k), sample(), exp_q[k]);
    end
  endtask

  // Advance to the sample point of the next fetch (F2) cycle, bounded.
  task automatic sync_f2();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.wIR !== 1'b1 && n < 60);
    checks++;
    if (bus.wIR !== 1'b1) begin
      errors++;
      $display("FAIL sync_f2: got no fetch within %0d cycles, required one", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t z, h;
    int   n;
    logic [3:0] rop;
    z = '0;
    h = '0; h.halted = 1'b1;
    tbl[0]  = '{4'b0000, 1'b0, 5,  "ADD"};
    tbl[1]  = '{4'b0010, 1'b0, 5,  "NDU"};
    tbl[2]  = '{4'b0001, 1'b0, 5,  "ADI"};
    tbl[3]  = '{4'b0011, 1'b0, 5,  "LHI"};
    tbl[4]  = '{4'b0100, 1'b0, 5,  "LW"};
    tbl[5]  = '{4'b0101, 1'b1, 5,  "SW"};
    tbl[6]  = '{4'b1100, 1'b1, 6,  "BEQ_taken"};
    tbl[7]  = '{4'b1100, 1'b0, 4,  "BEQ_not"};
    tbl[8]  = '{4'b1000, 1'b0, 6,  "JAL"};
    tbl[9]  = '{4'b1001, 1'b1, 6,  "JLR"};
    tbl[10] = '{4'b0110, 1'b0, 19, "LM"};
    tbl[11] = '{4'b0111, 1'b1, 19, "SM"};
    tbl[12] = '{4'b1010, 1'b0, 3,  "NOP_1010"};
    tbl[13] = '{4'b1110, 1'b1, 3,  "NOP_1110"};

    reset = 1'b1; bus.run = 1'b0; bus.opcode = 4'b0000; bus.compare = 1'b0;
    @(negedge clk);
    chk_ctl("reset_state", sample(), z);
    reset = 1'b0;
    @(negedge clk);
    chk_ctl("idle_run0", sample(), z);
    bus.run = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 14));
      run_model(rop, 1'($urandom_range(0, 1)));
    end

    // Instruction length table: cycles from F1 to the next F1.
    sync_f2();
    for (int i = 0; i < 14; i++) begin
      bus.opcode  = tbl[i].op;
      bus.compare = tbl[i].cmp;
      n = 2;
      do begin
        @(negedge clk);
        n++;
      end while (bus.wIR !== 1'b1 && n < 60);
      chk({tbl[i].name, "_len"}, n - 2, tbl[i].len);
    end

    // BEQ not taken: no RF write in EX
    bus.opcode = 4'b1100; bus.compare = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("beq_nt_ex_mux3", int'(bus.Mux3_RF_wen), 0);

    // run dropped mid-store: store completes, then IDLE
    sync_f2();
    bus.opcode = 4'b0101;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sw_run0_mem_write", int'(bus.Mux8_memwrite), 1);
    @(negedge clk);
    chk_ctl("sw_run0_idle", sample(), z);
    repeat (3) @(negedge clk);
    chk_ctl("idle_hold", sample(), z);
    bus.run = 1'b1;

    // reset asserted during SW MEM
    sync_f2();
    bus.opcode = 4'b0101;
    repeat (3) @(negedge clk);
    chk("sw_mem_write", int'(bus.Mux8_memwrite), 1);
    reset = 1'b1;
    #1;
    chk_ctl("rst_mid_sw", sample(), z);
    @(negedge clk);
    reset = 1'b0;

    // reset asserted mid-LM walk
    sync_f2();
    bus.opcode = 4'b0110;
    repeat (6) @(negedge clk);
    chk("lm_cnt_before_rst", int'(bus.counter), 2);
    reset = 1'b1;
    #1;
    chk_ctl("rst_mid_lm", sample(), z);
    @(negedge clk);
    reset = 1'b0;

    // HALT holds with run=1
    sync_f2();
    bus.opcode = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk_ctl("halt_entry", sample(), h);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("halt_hold_%0d", i), sample(), h);
    end
    reset = 1'b1;
    #1;
    chk_ctl("halt_reset", sample(), z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
